i2c_target: RTL and testbench
=============================

I2C_TARGET -- requirements
Module: i2c_target

Interface
REQ-001 Parameter DEVICE_ID, default 7'b1010_100, the 7-bit target address this block acknowledges.
REQ-002 Parameter FLT_LEN, default 3, the number of consecutive equal synchronized samples required before a filtered SCL/SDA level changes.
REQ-003 sys_clk  input  1  system clock; all logic is on its rising edge.
REQ-004 sys_rst_n  input  1  reset, asynchronous and active-low.
REQ-005 scl  input  1  I2C clock from the bus master, asynchronous to sys_clk.
REQ-006 sda  inout  1  I2C data, open-drain: driven 0 or high-Z only, never driven 1.
REQ-007 reg_addr  output  8  current register pointer.
REQ-008 reg_wr_data  output  8  byte received from the master.
REQ-009 reg_wr_en  output  1  one-cycle pulse; write reg_wr_data to reg_addr.
REQ-010 reg_rd_data  input  8  register contents at reg_addr; combinational from reg_addr, valid whenever reg_addr is stable.
REQ-011 reg_rd_en  output  1  one-cycle pulse when reg_rd_data is loaded for transmission.
REQ-012 busy  output  1  high from START until STOP.

Function
REQ-013 Each of scl and sda SHALL pass through a 2-flop synchronizer, then an FLT_LEN glitch filter; all edge detection uses the filtered levels.
REQ-014 START is filtered SDA falling while filtered SCL is high; STOP is filtered SDA rising while filtered SCL is high.
REQ-015 SDA is sampled on the cycle a filtered SCL rising edge is detected.
REQ-016 The SDA drive value changes only on the cycle a filtered SCL falling edge is detected.
REQ-017 States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT.
REQ-018 IDLE->ADDR on START; a bit counter (0..7) clears on entry to every byte state.
REQ-019 ADDR: shift 8 bits, MSB first. On the 8th rising edge:
- match with DEVICE_ID -> ADDR_ACK, latch the R/W bit;
- mismatch -> WAIT, SDA stays released.
REQ-020 ADDR_ACK: drive SDA 0 from the next SCL falling edge until the following falling edge, then:
- W -> PTR;
- R -> RD_DATA, loading reg_rd_data into the shift register and pulsing reg_rd_en on that falling edge.
REQ-021 PTR: on the 8th rising edge, load the byte into reg_addr and go to PTR_ACK (ACK driven 0); after the ACK falling edge go to WR_DATA.
REQ-022 WR_DATA: on the 8th rising edge, update reg_wr_data and pulse reg_wr_en with the current reg_addr; reg_addr increments the following cycle; go to WR_ACK (ACK driven 0), then back to WR_DATA.
REQ-023 RD_DATA: drive shift-register MSB-first on each falling edge (a 1 bit = release); after the 8th bit release SDA and go to RD_ACK; reg_addr increments on the cycle after reg_rd_en.
REQ-024 RD_ACK: sample SDA on the rising edge:
- 0 (ACK) -> RD_DATA, next byte loaded on the next falling edge;
- 1 (NACK) -> WAIT, SDA released.
REQ-025 WAIT: ignore bits; leave only on START or STOP.
REQ-026 reg_addr wraps 8'hFF->8'h00.
REQ-027 STOP in any state -> IDLE, SDA released at once, busy low.
REQ-028 START in any non-IDLE state (repeated START) -> ADDR; reg_addr is retained.
REQ-029 A START/STOP detected in the same cycle as an SCL edge takes priority over the edge.

Reset
REQ-030 Reset SHALL set the state to IDLE and all of the following to 0: reg_addr, reg_wr_data, reg_wr_en, reg_rd_en, busy.
REQ-031 Reset SHALL release SDA (high-Z) and preset the synchronizers and filters to 1.
REQ-032 Reset asserted mid-transfer SHALL release SDA within the reset assertion, without waiting for a clock.

Structure
REQ-033 A shared package SHALL hold the state encodings (one-hot, 10 bits) and the default DEVICE_ID constant.
REQ-034 The synchronizer plus glitch filter SHALL be one sub-module, i2c_in_filter, instantiated once for scl and once for sda.

Verification
REQ-035 Write with address 0xA8, pointer 0x10, data 0x5A, 0xC3, then STOP -> three ACKs; reg_wr_en pulses twice with (0x10,0x5A) and (0x11,0xC3); reg_addr ends at 0x12.
REQ-036 Write of pointer 0x20, then repeated START, address 0xA9, read two bytes with reg_rd_data = addr^0xFF, ACK then NACK -> SDA bits 0xDF then 0xDE; the block enters WAIT; reg_addr ends at 0x22.
REQ-037 Address 0xA6 -> no ACK (SDA high at the 9th rising edge), no reg_wr_en pulses, the block stays in WAIT until STOP.
REQ-038 Pointer 0xFF, write 0x11, 0x22 -> writes land at 0xFF then 0x00.
REQ-039 A 1-cycle SDA glitch while SCL is high (FLT_LEN=3) -> no START or STOP is detected; a STOP mid-byte returns the block to IDLE with busy=0.
REQ-040 sys_rst_n asserted while the block drives the ACK low -> SDA goes high-Z immediately; after release the next START is handled normally.

Source files
------------

// File: rtl/i2c_target_pkg.sv
// rtl/i2c_target_pkg.sv - shared constants and FSM encodings for the I2C register target
// Purpose: one-hot state encoding (10 bits), default target address and default
//          glitch-filter length used by i2c_target and i2c_in_filter.
// Ports:   none (package).
package i2c_target_pkg;

  localparam logic [6:0] DEFAULT_DEVICE_ID = 7'b1010_100;
  localparam int         DEFAULT_FLT_LEN   = 3;

  typedef enum logic [9:0] {
    ST_IDLE     = 10'b00_0000_0001,
    ST_ADDR     = 10'b00_0000_0010,
    ST_ADDR_ACK = 10'b00_0000_0100,
    ST_PTR      = 10'b00_0000_1000,
    ST_PTR_ACK  = 10'b00_0001_0000,
    ST_WR_DATA  = 10'b00_0010_0000,
    ST_WR_ACK   = 10'b00_0100_0000,
    ST_RD_DATA  = 10'b00_1000_0000,
    ST_RD_ACK   = 10'b01_0000_0000,
    ST_WAIT     = 10'b10_0000_0000
  } state_t;

endpackage

// File: rtl/i2c_in_filter.sv
// rtl/i2c_in_filter.sv - 2-flop synchronizer followed by a consecutive-sample glitch filter
// Purpose: brings an asynchronous bus line into sys_clk and only lets the output
//          change after FLT_LEN identical synchronized samples.
// Ports:   sys_clk, sys_rst_n (async, active-low) - clock and reset
//          din  - raw asynchronous line
//          dout - filtered level (resets to 1, the idle bus level)
module i2c_in_filter
  import i2c_target_pkg::*;
#(
  parameter int FLT_LEN = DEFAULT_FLT_LEN
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic din,
  output logic dout
);

  logic [1:0]         sync_q;
  logic [FLT_LEN-1:0] hist_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync_q <= 2'b11;
      hist_q <= '1;
      dout   <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], din};
      // Sliding window of the last FLT_LEN synchronized samples.
      hist_q <= FLT_LEN'({hist_q, sync_q[1]});
      if (&hist_q) begin
        dout <= 1'b1;
      end else if (~|hist_q) begin
        dout <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/i2c_target.sv
// rtl/i2c_target.sv - I2C target with an auto-incrementing 8-bit register pointer
// Purpose: acknowledges DEVICE_ID, takes the first written byte as the register
//          pointer, writes following bytes to the register port and serves reads.
// Ports:   sys_clk, sys_rst_n (async, active-low) - clock and reset
//          scl (in), sda (open-drain inout)       - I2C bus
//          reg_addr, reg_wr_data, reg_wr_en      - register pointer and write strobe
//          reg_rd_data (in), reg_rd_en           - read data and load strobe
//          busy                                  - high from START until STOP
module i2c_target
  import i2c_target_pkg::*;
#(
  parameter logic [6:0] DEVICE_ID = DEFAULT_DEVICE_ID,
  parameter int         FLT_LEN   = DEFAULT_FLT_LEN
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       scl,
  inout  wire        sda,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wr_data,
  output logic       reg_wr_en,
  input  logic [7:0] reg_rd_data,
  output logic       reg_rd_en,
  output logic       busy
);

  logic   scl_f, sda_f, scl_d, sda_d;
  logic   scl_rise, scl_fall, start_det, stop_det;
  logic   load_rd;
  state_t state_q, state_d;
  logic [2:0] bit_cnt;
  logic [7:0] shift_q, rx_byte;
  logic   rw_q, sda_oe, rd_load_q;

  i2c_in_filter #(.FLT_LEN(FLT_LEN)) u_scl_flt (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .din(scl), .dout(scl_f));
  i2c_in_filter #(.FLT_LEN(FLT_LEN)) u_sda_flt (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .din(sda), .dout(sda_f));

  // sda_oe has an async reset, so reset releases the line without a clock.
  assign sda = sda_oe ? 1'b0 : 1'bz;

  assign scl_rise  = scl_f & ~scl_d;
  assign scl_fall  = ~scl_f & scl_d;
  assign start_det = scl_f & sda_d & ~sda_f;
  assign stop_det  = scl_f & ~sda_d & sda_f;
  assign rx_byte   = {shift_q[6:0], sda_f};

  // Read byte load: end of the address ACK for a read, or the falling edge
  // after a master ACK.
  assign load_rd = ~stop_det & ~start_det & scl_fall &
                   (((state_q == ST_ADDR_ACK) & sda_oe & rw_q) |
                    ((state_q == ST_RD_DATA) & rd_load_q));

  always_comb begin
    state_d = state_q;
    if (stop_det) begin
      state_d = ST_IDLE;
    end else if (start_det) begin
      state_d = ST_ADDR;
    end else begin
      case (state_q)
        ST_ADDR:     if (scl_rise && bit_cnt == 3'd7)
                       state_d = (rx_byte[7:1] == DEVICE_ID) ? ST_ADDR_ACK : ST_WAIT;
        // In the ACK states sda_oe doubles as the phase flag: the first
        // falling edge starts driving, the second one ends the ACK.
        ST_ADDR_ACK: if (scl_fall && sda_oe) state_d = rw_q ? ST_RD_DATA : ST_PTR;
        ST_PTR:      if (scl_rise && bit_cnt == 3'd7) state_d = ST_PTR_ACK;
        ST_PTR_ACK:  if (scl_fall && sda_oe) state_d = ST_WR_DATA;
        ST_WR_DATA:  if (scl_rise && bit_cnt == 3'd7) state_d = ST_WR_ACK;
        ST_WR_ACK:   if (scl_fall && sda_oe) state_d = ST_WR_DATA;
        ST_RD_DATA:  if (scl_fall && !rd_load_q && bit_cnt == 3'd7) state_d = ST_RD_ACK;
        ST_RD_ACK:   if (scl_rise) state_d = sda_f ? ST_WAIT : ST_RD_DATA;
        default:     state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= ST_IDLE;
      scl_d       <= 1'b1;
      sda_d       <= 1'b1;
      bit_cnt     <= 3'd0;
      shift_q     <= 8'h00;
      rw_q        <= 1'b0;
      sda_oe      <= 1'b0;
      rd_load_q   <= 1'b0;
      reg_addr    <= 8'h00;
      reg_wr_data <= 8'h00;
      reg_wr_en   <= 1'b0;
      reg_rd_en   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q   <= state_d;
      scl_d     <= scl_f;
      sda_d     <= sda_f;
      reg_wr_en <= 1'b0;
      reg_rd_en <= 1'b0;
      if (reg_wr_en || reg_rd_en) begin
        reg_addr <= reg_addr + 8'd1;
      end

      if (stop_det) begin
        busy      <= 1'b0;
        sda_oe    <= 1'b0;
        rd_load_q <= 1'b0;
      end else if (start_det) begin
        busy      <= 1'b1;
        sda_oe    <= 1'b0;
        rd_load_q <= 1'b0;
        bit_cnt   <= 3'd0;
      end else begin
        case (state_q)
          ST_ADDR, ST_PTR, ST_WR_DATA: begin
            if (scl_rise) begin
              shift_q <= rx_byte;
              bit_cnt <= bit_cnt + 3'd1;  // wraps to 0 for the next byte state
              if (bit_cnt == 3'd7) begin
                if (state_q == ST_ADDR) rw_q <= rx_byte[0];
                if (state_q == ST_PTR)  reg_addr <= rx_byte;
                if (state_q == ST_WR_DATA) begin
                  reg_wr_data <= rx_byte;
                  reg_wr_en   <= 1'b1;
                end
              end
            end
          end
          ST_ADDR_ACK, ST_PTR_ACK, ST_WR_ACK: begin
            if (scl_fall) sda_oe <= ~sda_oe;
          end
          ST_RD_DATA: begin
            if (scl_fall && !rd_load_q) begin
              if (bit_cnt == 3'd7) begin
                sda_oe <= 1'b0;
              end else begin
                sda_oe  <= ~shift_q[7];
                shift_q <= {shift_q[6:0], 1'b0};
                bit_cnt <= bit_cnt + 3'd1;
              end
            end
          end
          ST_RD_ACK: begin
            if (scl_rise && !sda_f) begin
              rd_load_q <= 1'b1;
              bit_cnt   <= 3'd0;
            end
          end
          default: ;
        endcase

        // MSB goes out on the load edge; the rest shift out on later falls.
        if (load_rd) begin
          shift_q   <= {reg_rd_data[6:0], 1'b0};
          sda_oe    <= ~reg_rd_data[7];
          reg_rd_en <= 1'b1;
          rd_load_q <= 1'b0;
          bit_cnt   <= 3'd0;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c_target.sv
// tb/tb_i2c_target.sv - directed self-checking bench for i2c_target
module tb_i2c_target;

  localparam int Q = 100;
  localparam int H = 200;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       scl = 1'b1;
  logic       m_sda_low = 1'b0;
  wire        sda;
  logic [7:0] reg_addr, reg_wr_data, reg_rd_data;
  logic       reg_wr_en, reg_rd_en, busy;

  pullup (sda);
  assign sda = m_sda_low ? 1'b0 : 1'bz;
  assign reg_rd_data = reg_addr ^ 8'hFF;

  always #5 sys_clk = ~sys_clk;

  i2c_target dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .scl(scl), .sda(sda),
    .reg_addr(reg_addr), .reg_wr_data(reg_wr_data), .reg_wr_en(reg_wr_en),
    .reg_rd_data(reg_rd_data), .reg_rd_en(reg_rd_en), .busy(busy));

  logic [15:0] wr_log[$];
  int          rd_cnt = 0;

  always @(negedge sys_clk) begin
    if (reg_wr_en) wr_log.push_back({reg_addr, reg_wr_data});
    if (reg_rd_en) rd_cnt = rd_cnt + 1;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic bus_start();
    m_sda_low = 1'b0; #(Q); scl = 1'b1; #(H); m_sda_low = 1'b1; #(H); scl = 1'b0; #(Q);
  endtask

  task automatic bus_stop();
    m_sda_low = 1'b1; #(Q); scl = 1'b1; #(H); m_sda_low = 1'b0; #(H);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      m_sda_low = ~b[i]; #(Q); scl = 1'b1; #(H); scl = 1'b0; #(Q);
    end
  endtask

  task automatic get_ack(output logic ack_bit);
    m_sda_low = 1'b0; #(Q); scl = 1'b1; #(Q); ack_bit = sda; #(Q); scl = 1'b0; #(Q);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack_bit);
    send_bits(b, 8);
    get_ack(ack_bit);
  endtask

  task automatic read_byte(output logic [7:0] b, input logic master_ack);
    m_sda_low = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      #(Q); scl = 1'b1; #(Q); b[i] = sda; #(Q); scl = 1'b0; #(Q);
    end
    m_sda_low = master_ack; #(Q); scl = 1'b1; #(H); scl = 1'b0; #(Q);
    m_sda_low = 1'b0;
  endtask

  initial begin
    logic       a;
    logic [7:0] b;
    int         base, rc;

    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    check("rst_reg_addr", reg_addr, 8'h00);
    check("rst_wr_data", reg_wr_data, 8'h00);
    check("rst_wr_en", reg_wr_en, 1'b0);
    check("rst_rd_en", reg_rd_en, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_sda", sda, 1'b1);
    sys_rst_n = 1'b1;
    repeat (20) @(posedge sys_clk);

    // Write: pointer 0x10, data 0x5A, 0xC3
    base = wr_log.size();
    bus_start();
    write_byte(8'hA8, a); check("w_addr_ack", a, 1'b0);
    write_byte(8'h10, a); check("w_ptr_ack", a, 1'b0);
    check("w_busy", busy, 1'b1);
    write_byte(8'h5A, a); check("w_d0_ack", a, 1'b0);
    write_byte(8'hC3, a); check("w_d1_ack", a, 1'b0);
    bus_stop();
    check("w_count", wr_log.size() - base, 2);
    check("w_ev0", wr_log[base], 16'h105A);
    check("w_ev1", wr_log[base+1], 16'h11C3);
    check("w_addr_end", reg_addr, 8'h12);
    check("w_busy_end", busy, 1'b0);

    // Pointer 0x20, repeated START, read two bytes (ACK then NACK)
    base = wr_log.size();
    rc = rd_cnt;
    bus_start();
    write_byte(8'hA8, a); check("r_waddr_ack", a, 1'b0);
    write_byte(8'h20, a); check("r_ptr_ack", a, 1'b0);
    bus_start();
    write_byte(8'hA9, a); check("r_raddr_ack", a, 1'b0);
    read_byte(b, 1'b1); check("r_byte0", b, 8'hDF);
    read_byte(b, 1'b0); check("r_byte1", b, 8'hDE);
    read_byte(b, 1'b0); check("r_wait_released", b, 8'hFF);
    check("r_rd_pulses", rd_cnt - rc, 2);
    check("r_addr_end", reg_addr, 8'h22);
    check("r_busy_wait", busy, 1'b1);
    bus_stop();
    check("r_busy_end", busy, 1'b0);
    check("r_no_writes", wr_log.size() - base, 0);

    // Wrong address 0xA6: no ACK, subsequent bytes ignored until STOP
    base = wr_log.size();
    bus_start();
    write_byte(8'hA6, a); check("n_addr_nack", a, 1'b1);
    write_byte(8'h00, a); check("n_wait_nack", a, 1'b1);
    check("n_busy_wait", busy, 1'b1);
    bus_stop();
    check("n_busy_end", busy, 1'b0);
    check("n_no_writes", wr_log.size() - base, 0);

    // Pointer wrap 0xFF -> 0x00
    base = wr_log.size();
    bus_start();
    write_byte(8'hA8, a); check("x_addr_ack", a, 1'b0);
    write_byte(8'hFF, a); check("x_ptr_ack", a, 1'b0);
    write_byte(8'h11, a); check("x_d0_ack", a, 1'b0);
    write_byte(8'h22, a); check("x_d1_ack", a, 1'b0);
    bus_stop();
    check("x_count", wr_log.size() - base, 2);
    check("x_ev0", wr_log[base], 16'hFF11);
    check("x_ev1", wr_log[base+1], 16'h0022);
    check("x_addr_end", reg_addr, 8'h01);

    // Single-cycle SDA glitches while SCL high; STOP in the middle of a byte
    base = wr_log.size();
    @(posedge sys_clk); #2; m_sda_low = 1'b1;
    @(posedge sys_clk); #2; m_sda_low = 1'b0;
    repeat (20) @(posedge sys_clk);
    check("g_no_start", busy, 1'b0);
    bus_start();
    write_byte(8'hA8, a); check("g_addr_ack", a, 1'b0);
    send_bits(8'hA0, 3);
    m_sda_low = 1'b1; #(Q); scl = 1'b1; #(Q);
    @(posedge sys_clk); #2; m_sda_low = 1'b0;
    @(posedge sys_clk); #2; m_sda_low = 1'b1;
    #(Q);
    check("g_no_stop", busy, 1'b1);
    m_sda_low = 1'b0; #(H);
    check("g_stop_mid_byte", busy, 1'b0);
    check("g_no_writes", wr_log.size() - base, 0);
    check("g_addr_kept", reg_addr, 8'h01);

    // Reset while the target holds the ACK low
    bus_start();
    send_bits(8'hA8, 8);
    m_sda_low = 1'b0; #(Q); scl = 1'b1; #(Q);
    check("z_ack_driven", sda, 1'b0);
    sys_rst_n = 1'b0;
    #1;
    check("z_sda_released", sda, 1'b1);
    check("z_busy", busy, 1'b0);
    check("z_reg_addr", reg_addr, 8'h00);
    #(Q); scl = 1'b0; #(Q);
    @(negedge sys_clk); sys_rst_n = 1'b1;
    #(H);
    bus_stop();
    base = wr_log.size();
    bus_start();
    write_byte(8'hA8, a); check("z_addr_ack", a, 1'b0);
    write_byte(8'h40, a); check("z_ptr_ack", a, 1'b0);
    write_byte(8'h77, a); check("z_d0_ack", a, 1'b0);
    bus_stop();
    check("z_count", wr_log.size() - base, 1);
    check("z_ev0", wr_log[base], 16'h4077);
    check("z_addr_end", reg_addr, 8'h41);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
